// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC generation, 1-cycle-latency imem requests,
// and a 2-entry {inst, pc} queue handed to decode over valid/ready.
module if_fetch_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0] fetch_pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              rst_q;
    logic              head_q, tail_q;
    logic [1:0]        count_q;
    logic [31:0]       inst_mem [2];
    logic [ADDR_W-1:0] pc_mem   [2];

    logic              pop, push;
    logic [2:0]        occupancy;

    always_comb begin
        out_valid = (count_q != 2'd0);
        out_inst  = out_valid ? inst_mem[head_q] : 32'd0;
        out_pc    = out_valid ? pc_mem[head_q] : '0;
        pop       = out_valid & out_ready;
        push      = inflight_q & ~redirect_valid;
        // Credit check: buffered + in-flight entries, minus the one leaving now.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        imem_req  = ~rst_q & ~redirect_valid & (occupancy < 3'(DEPTH));
        imem_addr = fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= 2'd0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc & ~ADDR_W'(3);
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fetch_pc_q    <= fetch_pc_q + ADDR_W'(4);
                inflight_pc_q <= fetch_pc_q;
            end
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset; count_q alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]   <= inflight_pc_q;
        end
    end

endmodule
